// File: rtl/irq_controller_pkg.sv
// ---------------------------------------------------------------------------
// irq_controller_pkg
//   Shared definitions for the interrupt controller:
//   - FSM state encoding (IDLE / REQ / SERVICE)
//   - configuration register addresses
//   - STATUS register field positions
// ---------------------------------------------------------------------------
package irq_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Configuration register map
  localparam logic [1:0] CFG_MASK = 2'd0;
  localparam logic [1:0] CFG_PEND = 2'd1;
  localparam logic [1:0] CFG_STAT = 2'd2;
  localparam logic [1:0] CFG_EOI  = 2'd3;

  // STATUS register layout
  localparam int STAT_STATE_LSB = 16;
  localparam int STAT_STATE_W   = 2;
  localparam int STAT_ID_LSB    = 0;

endpackage

// File: rtl/irq_sync_edge.sv
// ---------------------------------------------------------------------------
// irq_sync_edge
//   Two-flop synchroniser for one asynchronous interrupt source, with an
//   optional history flop for rising-edge detection.
//
//   Ports:
//     clk   in   system clock
//     rst   in   asynchronous active-high reset
//     din   in   raw source, asynchronous to clk
//     trig  out  EdgeMode=1: one-cycle rising-edge pulse (s2 & ~s3)
//                EdgeMode=0: synchronised level (s2)
// ---------------------------------------------------------------------------
module irq_sync_edge #(
  parameter bit EdgeMode = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic trig
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  generate
    if (EdgeMode) begin : g_edge
      logic s3;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s3 <= 1'b0;
        end else begin
          s3 <= s2;
        end
      end

      assign trig = s2 & ~s3;
    end else begin : g_level
      assign trig = s2;
    end
  endgenerate

endmodule

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//   Interrupt controller feeding the processor's single IRQ input.
//   Synchronises NumSrc sources, latches (edge) or follows (level) them,
//   masks them, picks the lowest eligible index and runs a
//   request / acknowledge / end-of-interrupt handshake.
//
//   Ports:
//     clk        in   system clock
//     RESET      in   asynchronous active-high reset
//     irq_src    in   raw interrupt sources [NumSrc-1:0]
//     pc_31      in   supervisor bit; 1 blocks new requests
//     irq_ack    in   one-cycle pulse when the exception is taken
//     cfg_we     in   config write strobe
//     cfg_addr   in   config register select (MASK/PEND/STAT/EOI)
//     cfg_wdata  in   config write data
//     cfg_rdata  out  config read data, combinational from cfg_addr
//     IRQ        out  registered interrupt request
//     irq_id     out  registered index of requested / in-service source
//     irq_busy   out  high while in SERVICE
// ---------------------------------------------------------------------------
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int                NumSrc   = 8,
  parameter int                IdW      = 3,
  parameter logic [NumSrc-1:0] EdgeMask = {NumSrc{1'b1}}
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [NumSrc-1:0] irq_src,
  input  logic              pc_31,
  input  logic              irq_ack,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              IRQ,
  output logic [IdW-1:0]    irq_id,
  output logic              irq_busy
);

  irq_state_e        state_reg;
  irq_state_e        state_next;
  logic              irq_reg;
  logic              irq_next;
  logic [IdW-1:0]    id_reg;
  logic [IdW-1:0]    id_next;

  logic [NumSrc-1:0] trig;
  logic [NumSrc-1:0] pending;
  logic [NumSrc-1:0] mask_reg;
  logic [NumSrc-1:0] eligible;
  logic [NumSrc-1:0] ack_clr;
  logic [NumSrc-1:0] pend_clr;
  logic [IdW-1:0]    winner;

  logic              mask_wr;
  logic              pend_wr;
  logic              eoi_wr;
  logic              wdata_unused;

  assign mask_wr = cfg_we && (cfg_addr == CFG_MASK);
  assign pend_wr = cfg_we && (cfg_addr == CFG_PEND);
  assign eoi_wr  = cfg_we && (cfg_addr == CFG_EOI);

  // Only the low NumSrc data bits carry meaning; EOI ignores the data.
  assign wdata_unused = ^cfg_wdata;

  // Write-1-to-clear from the config port plus the acknowledge clear.
  assign pend_clr = ack_clr | (pend_wr ? cfg_wdata[NumSrc-1:0] : '0);

  // -------------------------------------------------------------------------
  // Per-source synchroniser and pending bit
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NumSrc; gi++) begin : g_src
      irq_sync_edge #(
        .EdgeMode (EdgeMask[gi])
      ) u_sync (
        .clk  (clk),
        .rst  (RESET),
        .din  (irq_src[gi]),
        .trig (trig[gi])
      );

      if (EdgeMask[gi]) begin : g_edge_pend
        logic pend_bit;

        // A new edge in the same cycle as a clear keeps the bit set.
        always_ff @(posedge clk or posedge RESET) begin
          if (RESET) begin
            pend_bit <= 1'b0;
          end else begin
            pend_bit <= trig[gi] | (pend_bit & ~pend_clr[gi]);
          end
        end

        assign pending[gi] = pend_bit;
      end else begin : g_level_pend
        // Level sources simply follow the synchronised input.
        assign pending[gi] = trig[gi];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Mask register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      mask_reg <= '0;
    end else if (mask_wr) begin
      mask_reg <= cfg_wdata[NumSrc-1:0];
    end
  end

  assign eligible = pending & mask_reg;

  // Fixed priority: lowest eligible index wins.
  always_comb begin
    winner = '0;
    for (int i = NumSrc - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = IdW'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Handshake FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      irq_reg   <= 1'b0;
      id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      irq_reg   <= irq_next;
      id_reg    <= id_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    irq_next   = irq_reg;
    id_next    = id_reg;
    ack_clr    = '0;

    case (state_reg)
      ST_IDLE: begin
        if ((|eligible) && !pc_31) begin
          state_next = ST_REQ;
          irq_next   = 1'b1;
          id_next    = winner;
        end
      end

      ST_REQ: begin
        // Acknowledge beats a simultaneous withdrawal; irq_id never
        // changes while the request is outstanding.
        if (irq_ack) begin
          state_next      = ST_SERVICE;
          irq_next        = 1'b0;
          ack_clr[id_reg] = 1'b1;
        end else if (!eligible[id_reg]) begin
          state_next = ST_IDLE;
          irq_next   = 1'b0;
        end
      end

      ST_SERVICE: begin
        irq_next = 1'b0;
        if (eoi_wr) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        irq_next   = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs and config read mux
  // -------------------------------------------------------------------------
  assign IRQ      = irq_reg;
  assign irq_id   = id_reg;
  assign irq_busy = (state_reg == ST_SERVICE);

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      CFG_MASK: cfg_rdata[NumSrc-1:0] = mask_reg;
      CFG_PEND: cfg_rdata[NumSrc-1:0] = pending;
      CFG_STAT: begin
        cfg_rdata[STAT_STATE_LSB +: STAT_STATE_W] = state_reg;
        cfg_rdata[STAT_ID_LSB +: IdW]             = id_reg;
      end
      default: cfg_rdata = '0;
    endcase
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller in front of the processor's single IRQ input.
- Synchronises NumSrc external sources, latches and masks them, and picks one by fixed priority.
- Drives IRQ through a request/acknowledge/end-of-interrupt handshake, so the exception path (XAddr entry, XPReg save) runs exactly once per serviced interrupt.
- Configured by the supervisor through a small register port.

Parameters:
- NumSrc, 8, number of interrupt sources (1..32).
- IdW, 3, width of the source index; must equal ceil(log2(NumSrc)), minimum 1.
- EdgeMask, 8'hFF, per-source mode: 1 = rising-edge latched, 0 = level.

Ports:
- clk  input  1  system clock; all state on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- irq_src  input  NumSrc  raw interrupt sources, asynchronous to clk.
- pc_31  input  1  processor supervisor bit (InstAdd[31]); 1 = kernel mode.
- irq_ack  input  1  one-cycle pulse from control logic when the exception is taken (PCSEL selects XAddr).
- cfg_we  input  1  config write strobe.
- cfg_addr  input  2  config register select.
- cfg_wdata  input  32  config write data.
- cfg_rdata  output  32  config read data, combinational from cfg_addr.
- IRQ  output  1  interrupt request to the processor, registered.
- irq_id  output  IdW  index of the requested/in-service source, registered.
- irq_busy  output  1  high in state SERVICE.

Behaviour:
- Reset:
  - MASK=0, PENDING=0, sync flops=0, state IDLE.
  - IRQ=0, irq_id=0, irq_busy=0.
  - Reset mid-REQ or mid-SERVICE abandons the interrupt silently.
- Synchroniser:
  - Two flops per source (s1, s2), plus a history flop s3 for edge sources.
- PENDING[i], edge source:
  - Set when s2 & ~s3.
  - This occurs at the 3rd rising clk edge that samples irq_src[i] high after a low.
  - Cleared by acknowledge or by a config write-1-to-clear.
  - A set and a clear in the same cycle leave the bit set.
- PENDING[i], level source:
  - Equals s2, i.e. the 2nd edge sampling high; writes are ignored.
- Eligible: PENDING & MASK. Winner = lowest eligible index.
- State IDLE:
  - Go to REQ if any bit is eligible and pc_31==0.
  - On that transition set IRQ=1 and latch irq_id=winner.
  - IRQ is therefore high one edge after PENDING sets (edge source: 4th edge).
- State REQ, in priority order:
  - irq_ack=1: go to SERVICE, IRQ=0, clear PENDING[irq_id] if it is an edge source. Ack wins over withdrawal in the same cycle.
  - Else if eligible[irq_id]==0 (masked or level dropped): go to IDLE, IRQ=0.
  - Else hold.
  - irq_id is stable throughout REQ; a higher-priority arrival does not preempt.
- State SERVICE:
  - irq_busy=1 and IRQ=0.
  - New pendings accumulate.
  - An EOI write moves to IDLE; re-arbitration occurs from the next cycle.
  - EOI written in IDLE or REQ is ignored.
- irq_ack outside REQ is ignored.
- Config registers:
  - addr 0, MASK: R/W, bits [NumSrc-1:0].
  - addr 1, PENDING: R; a write of 1 clears edge bits.
  - addr 2, STATUS: R, {state[1:0] at bits 17:16, irq_id at [IdW-1:0]}.
  - addr 3, EOI: W, any data; reads as 0.
  - Unused read bits are 0. Config writes take effect at the edge of cfg_we.
- State encoding: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2; 2'd3 is illegal and goes to IDLE.

Decomposition:
- Shared package: state encodings, config address constants (CFG_MASK=0, CFG_PEND=1, CFG_STAT=2, CFG_EOI=3), STATUS field positions.
- One natural sub-module, irq_sync_edge: per-source 2-flop synchroniser plus edge detect, instantiated NumSrc times.
- Priority encoder and FSM stay in the top module.

Test Plan:
- After RESET, write MASK=8'h04; pulse irq_src[2] high for 5 cycles -> PENDING=8'h04 at the 3rd edge, IRQ=1 and irq_id=2 at the 4th; irq_ack -> IRQ=0, irq_busy=1, PENDING=0; EOI write -> state IDLE.
- MASK=8'hFF; raise sources 5 and 1 on the same edge -> irq_id=1. Ack plus EOI -> next request irq_id=5.
- Bit 3 pending, MASK=0 -> IRQ stays 0; write MASK=8'h08 -> IRQ=1 within 1 edge. While in REQ, write MASK=0 -> IRQ=0 next edge, state IDLE, PENDING[3] still 1.
- pc_31=1 with eligible source 0 -> IRQ held 0; drop pc_31 -> IRQ=1 next edge, irq_id=0.
- In SERVICE for source 0, a second edge on source 0 -> PENDING[0]=1, IRQ stays 0 until EOI, then re-requests irq_id=0.
- Assert RESET asynchronously mid-REQ (IRQ=1) -> IRQ, irq_id, MASK, PENDING all 0 immediately, without waiting for a clock edge.
